// File: rtl/pmem_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped program-memory cache.
// Every cache file imports this package.
package pmem_cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StFill,
    StRespond
  } state_e;

  function automatic int unsigned index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                           input int unsigned num_lines);
    return addr_bits - $clog2(num_lines);
  endfunction

  // A single channel still needs a 1-bit select so that port widths stay legal.
  function automatic int unsigned sel_bits(input int unsigned num_consumers);
    return (num_consumers > 1) ? $clog2(num_consumers) : 1;
  endfunction

endpackage

// File: rtl/pmem_cache_rr_arbiter.sv
// Combinational round-robin picker. It grants the first requester at or after ptr,
// and it wraps around to the lower channels when no higher channel is requesting.
module pmem_cache_rr_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 2,
  parameter int unsigned SEL_BITS      = 1
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [SEL_BITS-1:0]      ptr,
  output logic [NUM_CONSUMERS-1:0] grant,
  output logic [SEL_BITS-1:0]      grant_idx,
  output logic                     any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // First pass covers [ptr, N). Second pass wraps around to [0, ptr).
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/pmem_cache.sv
// Direct-mapped, read-only instruction cache. It sits between the fetcher channels and a
// single program-memory port, and it keeps saturating hit and miss counters.
module pmem_cache
  import pmem_cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 2,
  parameter int unsigned NUM_LINES     = 16,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               invalidate,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic [CNT_BITS-1:0]                hit_count,
  output logic [CNT_BITS-1:0]                miss_count,
  output logic                               busy
);

  localparam int unsigned IdxBits = index_bits(NUM_LINES);
  localparam int unsigned TagBits = tag_bits(ADDR_BITS, NUM_LINES);
  localparam int unsigned SelBits = sel_bits(NUM_CONSUMERS);

  state_e                     state_q;
  logic [NUM_LINES-1:0]       valid_q;
  logic [NUM_CONSUMERS-1:0]   armed_q;
  logic [SelBits-1:0]         rr_ptr_q;
  logic [SelBits-1:0]         grant_q;
  logic [ADDR_BITS-1:0]       addr_q;
  logic                       inv_pend_q;
  logic [NUM_CONSUMERS-1:0]   ready_q;
  logic [DATA_BITS-1:0]       resp_data_q;
  logic                       mem_valid_q;
  logic [ADDR_BITS-1:0]       mem_addr_q;
  logic [CNT_BITS-1:0]        hit_count_q;
  logic [CNT_BITS-1:0]        miss_count_q;

  logic [DATA_BITS-1:0]       data_arr [NUM_LINES];
  logic [TagBits-1:0]         tag_arr  [NUM_LINES];

  logic [NUM_CONSUMERS-1:0]   arb_req;
  logic [NUM_CONSUMERS-1:0]   arb_grant;
  logic [SelBits-1:0]         arb_idx;
  logic                       arb_any;
  logic [SelBits-1:0]         rr_next;
  logic [ADDR_BITS-1:0]       req_addr;
  logic [IdxBits-1:0]         line_idx;
  logic                       lookup_hit;

  // A channel can only be granted after it has dropped valid following its last response.
  assign arb_req = consumer_read_valid & armed_q;

  pmem_cache_rr_arbiter #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .SEL_BITS     (SelBits)
  ) u_arbiter (
    .req      (arb_req),
    .ptr      (rr_ptr_q),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .any      (arb_any)
  );

  always_comb begin
    req_addr = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (arb_grant[i]) req_addr = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  assign rr_next    = (arb_idx == SelBits'(NUM_CONSUMERS - 1)) ? '0 : arb_idx + 1'b1;
  assign line_idx   = addr_q[IdxBits-1:0];
  assign lookup_hit = valid_q[line_idx] && (tag_arr[line_idx] == addr_q[ADDR_BITS-1:IdxBits]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      armed_q      <= '1;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      inv_pend_q   <= 1'b0;
      ready_q      <= '0;
      resp_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
        if (!consumer_read_valid[i]) armed_q[i] <= 1'b1;
      end
      if (invalidate && (state_q != StIdle)) inv_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (invalidate) valid_q <= '0;
          if (arb_any) begin
            grant_q  <= arb_idx;
            addr_q   <= req_addr;
            rr_ptr_q <= rr_next;
            state_q  <= StLookup;
          end
        end
        StLookup: begin
          if (lookup_hit) begin
            if (hit_count_q != '1) hit_count_q <= hit_count_q + 1'b1;
            resp_data_q      <= data_arr[line_idx];
            ready_q[grant_q] <= 1'b1;
            state_q          <= StRespond;
          end else begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + 1'b1;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= addr_q;
            state_q     <= StFill;
          end
        end
        StFill: begin
          if (mem_read_ready) begin
            mem_valid_q       <= 1'b0;
            valid_q[line_idx] <= 1'b1;
            resp_data_q       <= mem_read_data;
            ready_q[grant_q]  <= 1'b1;
            state_q           <= StRespond;
          end
        end
        StRespond: begin
          ready_q          <= '0;
          armed_q[grant_q] <= 1'b0;
          state_q          <= StIdle;
          // A deferred invalidate lands on the edge that returns to idle.
          // It may have arrived during this very cycle.
          if (inv_pend_q || invalidate) begin
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The payload arrays have no reset. The valid bits are the only thing that must start clean.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StFill) && mem_read_ready) begin
      data_arr[line_idx] <= mem_read_data;
      tag_arr[line_idx]  <= addr_q[ADDR_BITS-1:IdxBits];
    end
  end

  always_comb begin
    consumer_read_data = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (ready_q[i]) consumer_read_data[i*DATA_BITS +: DATA_BITS] = resp_data_q;
    end
  end

  assign consumer_read_ready = ready_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign hit_count           = hit_count_q;
  assign miss_count          = miss_count_q;
  assign busy                = (state_q != StIdle);

endmodule
